// File: rtl/sift_pkg.sv
// Shared SIFT pipeline constants and types.
// Holds the frame geometry, the DoG pixel width and the DoG stage state encoding.
package sift_pkg;

  localparam int ROWS = 480;
  localparam int PIX  = 640;
  localparam int PW   = 8;
  localparam int AW   = 9;
  localparam int DW   = PW + 1;

  localparam int BLUR_ROW_W = PIX * PW;
  localparam int DOG_ROW_W  = PIX * DW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dog_state_e;

  // Address of the final row; also the value rd_addr holds once a sweep ends.
  function automatic logic [AW-1:0] last_row_addr();
    return AW'(ROWS - 1);
  endfunction

endpackage

// File: rtl/dog_subtract_if.sv
// Bus between the DoG stage and its blur/DoG SRAM neighbours.
// The slave modport is the DoG stage; the master side is the SRAM/control environment.
interface dog_subtract_if;
  import sift_pkg::*;

  logic                  start;
  logic                  done;
  logic                  rd_en;
  logic [AW-1:0]         rd_addr;
  logic [BLUR_ROW_W-1:0] blur_dout_0;
  logic [BLUR_ROW_W-1:0] blur_dout_1;
  logic [BLUR_ROW_W-1:0] blur_dout_2;
  logic [BLUR_ROW_W-1:0] blur_dout_3;
  logic                  dog_we;
  logic [AW-1:0]         dog_addr;
  logic [DOG_ROW_W-1:0]  dog_din_0;
  logic [DOG_ROW_W-1:0]  dog_din_1;
  logic [DOG_ROW_W-1:0]  dog_din_2;

  modport master (
    output start,
    output blur_dout_0, blur_dout_1, blur_dout_2, blur_dout_3,
    input  done,
    input  rd_en, rd_addr,
    input  dog_we, dog_addr,
    input  dog_din_0, dog_din_1, dog_din_2
  );

  modport slave (
    input  start,
    input  blur_dout_0, blur_dout_1, blur_dout_2, blur_dout_3,
    output done,
    output rd_en, rd_addr,
    output dog_we, dog_addr,
    output dog_din_0, dog_din_1, dog_din_2
  );

endinterface

// File: rtl/dog_row_sub.sv
// Combinational row-wide subtractor: diff = hi - lo per pixel, zero-extended to PW+1 bits.
// Unsigned PW-bit inputs give a result that always fits in PW+1 bits two's complement.
module dog_row_sub #(
  parameter int PIX = 640,
  parameter int PW  = 8
) (
  input  logic [PIX*PW-1:0]     hi_i,
  input  logic [PIX*PW-1:0]     lo_i,
  output logic [PIX*(PW+1)-1:0] diff_o
);

  for (genvar i = 0; i < PIX; i++) begin : g_pix
    assign diff_o[i*(PW+1) +: PW+1] = {1'b0, hi_i[i*PW +: PW]} - {1'b0, lo_i[i*PW +: PW]};
  end

endmodule

// File: rtl/dog_subtract.sv
// Difference-of-Gaussian stage: sweeps the four blur SRAMs in lockstep and writes
// three signed DoG rows per input row, one frame per start pulse.
module dog_subtract
  import sift_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  dog_subtract_if.slave  bus
);

  dog_state_e     state_q;
  logic           rd_en_q;
  logic [AW-1:0]  rd_addr_q;
  logic           drain_q;
  logic           done_q;

  logic           vld1_q;
  logic [AW-1:0]  addr1_q;
  logic           dog_we_q;
  logic [AW-1:0]  dog_addr_q;
  logic [DOG_ROW_W-1:0] dog_din0_q, dog_din1_q, dog_din2_q;
  logic [DOG_ROW_W-1:0] dog_din0_d, dog_din1_d, dog_din2_d;

  dog_row_sub #(.PIX(PIX), .PW(PW)) u_sub0 (
    .hi_i   (bus.blur_dout_1),
    .lo_i   (bus.blur_dout_0),
    .diff_o (dog_din0_d)
  );

  dog_row_sub #(.PIX(PIX), .PW(PW)) u_sub1 (
    .hi_i   (bus.blur_dout_2),
    .lo_i   (bus.blur_dout_1),
    .diff_o (dog_din1_d)
  );

  dog_row_sub #(.PIX(PIX), .PW(PW)) u_sub2 (
    .hi_i   (bus.blur_dout_3),
    .lo_i   (bus.blur_dout_2),
    .diff_o (dog_din2_d)
  );

  // Frame sequencer: RUN issues one read row per cycle, DRAIN covers the two
  // pipeline stages behind the last read, DONE pulses done for one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      drain_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q    <= 1'b0;
          rd_addr_q <= '0;
          if (bus.start) begin
            state_q <= RUN;
            rd_en_q <= 1'b1;
          end
        end
        RUN: begin
          if (rd_addr_q == last_row_addr()) begin
            state_q <= DRAIN;
            rd_en_q <= 1'b0;
            drain_q <= 1'b0;
          end else begin
            rd_addr_q <= rd_addr_q + AW'(1);
          end
        end
        DRAIN: begin
          if (drain_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            drain_q <= 1'b0;
          end else begin
            drain_q <= 1'b1;
          end
        end
        DONE: begin
          state_q   <= IDLE;
          done_q    <= 1'b0;
          rd_addr_q <= '0;
        end
        default: begin
          state_q   <= IDLE;
          rd_en_q   <= 1'b0;
          rd_addr_q <= '0;
          drain_q   <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  // Two-stage address/valid delay matching the SRAM read latency plus the
  // output register; dog_din only loads when the SRAM data is valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld1_q     <= 1'b0;
      addr1_q    <= '0;
      dog_we_q   <= 1'b0;
      dog_addr_q <= '0;
      dog_din0_q <= '0;
      dog_din1_q <= '0;
      dog_din2_q <= '0;
    end else begin
      vld1_q     <= rd_en_q;
      addr1_q    <= rd_addr_q;
      dog_we_q   <= vld1_q;
      dog_addr_q <= addr1_q;
      if (vld1_q) begin
        dog_din0_q <= dog_din0_d;
        dog_din1_q <= dog_din1_d;
        dog_din2_q <= dog_din2_d;
      end
    end
  end

  assign bus.done      = done_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.dog_we    = dog_we_q;
  assign bus.dog_addr  = dog_addr_q;
  assign bus.dog_din_0 = dog_din0_q;
  assign bus.dog_din_1 = dog_din1_q;
  assign bus.dog_din_2 = dog_din2_q;

endmodule

// File: tb/tb_dog_subtract.sv
// Directed bench for dog_subtract: blur SRAM model with selectable row patterns,
// per-cycle frame timing checks and expected DoG rows computed from pixel arithmetic.
module tb_dog_subtract;
  import sift_pkg::*;

  logic clk;
  logic rst_n;
  int   curMode;
  int   compared;
  int   mismatched;

  dog_subtract_if bus();

  dog_subtract dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Blur pixel pattern: 0 = directed corner values, 1 = ramp with level offset 3k,
  // 2 = row tag in level 1 (pixel0 = row[7:0], pixel1 = row[8]).
  function automatic logic [PW-1:0] pixVal(input int mode, input int k, input int r, input int i);
    int v;
    v = 77;
    if (mode == 0) begin
      if (k == 0 && i == 0) v = 10;
      if (k == 1 && i == 0) v = 25;
      if (k == 2 && i == 1) v = 255;
      if (k == 3 && i == 1) v = 0;
    end else if (mode == 1) begin
      v = ((r % 256) + 3 * k) % 256;
    end else begin
      if (i == 0)      v = (k == 1) ? (r % 256) : 0;
      else if (i == 1) v = (k == 1) ? (r / 256) : 0;
      else             v = 3 * k;
    end
    return PW'(v);
  endfunction

  function automatic logic [BLUR_ROW_W-1:0] buildRow(input int mode, input int k, input int r);
    logic [BLUR_ROW_W-1:0] row;
    row = '0;
    for (int i = 0; i < PIX; i++) row[i*PW +: PW] = pixVal(mode, k, r, i);
    return row;
  endfunction

  function automatic logic [DOG_ROW_W-1:0] expRow(input int mode, input int k, input int r);
    logic [DOG_ROW_W-1:0] row;
    int d;
    row = '0;
    for (int i = 0; i < PIX; i++) begin
      d = int'(pixVal(mode, k + 1, r, i)) - int'(pixVal(mode, k, r, i));
      row[i*DW +: DW] = DW'(d);
    end
    return row;
  endfunction

  // Registered-read blur SRAMs: data for rd_addr appears the cycle after.
  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.blur_dout_0 <= buildRow(curMode, 0, int'(bus.rd_addr));
      bus.blur_dout_1 <= buildRow(curMode, 1, int'(bus.rd_addr));
      bus.blur_dout_2 <= buildRow(curMode, 2, int'(bus.rd_addr));
      bus.blur_dout_3 <= buildRow(curMode, 3, int'(bus.rd_addr));
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
    end
  endtask

  // Compares a whole DoG row through one check on the first differing pixel.
  task automatic checkRow(input string tag, input logic [DOG_ROW_W-1:0] act, input logic [DOG_ROW_W-1:0] exp);
    int idx;
    idx = 0;
    for (int i = 0; i < PIX; i++) begin
      if (act[i*DW +: DW] !== exp[i*DW +: DW]) begin
        idx = i;
        break;
      end
    end
    checkOutput($sformatf("%s px%0d", tag, idx), 64'(act[idx*DW +: DW]), 64'(exp[idx*DW +: DW]));
  endtask

  task automatic checkAllZero(input string tag);
    logic [DOG_ROW_W-1:0] zeroRow;
    zeroRow = '0;
    checkOutput({tag, " done"},     64'(bus.done),     64'(0));
    checkOutput({tag, " rd_en"},    64'(bus.rd_en),    64'(0));
    checkOutput({tag, " rd_addr"},  64'(bus.rd_addr),  64'(0));
    checkOutput({tag, " dog_we"},   64'(bus.dog_we),   64'(0));
    checkOutput({tag, " dog_addr"}, 64'(bus.dog_addr), 64'(0));
    checkRow({tag, " din0"}, bus.dog_din_0, zeroRow);
    checkRow({tag, " din1"}, bus.dog_din_1, zeroRow);
    checkRow({tag, " din2"}, bus.dog_din_2, zeroRow);
  endtask

  // Runs one frame from the current negedge (start high in cycle 0) and checks
  // every cycle 1..ROWS+4; optional start re-pulses and a mid-frame reset.
  task automatic applyStimulus(input string tag, input int mode, input bit repulse, input int abortAt);
    int expRdAddr;
    bit expRdEn, expWe, expDone;
    curMode = mode;
    bus.start = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= ROWS + 4; c++) begin
      bus.start = repulse && (c == 100 || c == ROWS + 1 || c == ROWS + 3);
      expRdEn   = (c <= ROWS);
      expRdAddr = (c <= ROWS) ? c - 1 : ((c <= ROWS + 3) ? ROWS - 1 : 0);
      expWe     = (c >= 3 && c <= ROWS + 2);
      expDone   = (c == ROWS + 3);
      checkOutput($sformatf("%s c%0d rd_en", tag, c),   64'(bus.rd_en),   64'(expRdEn));
      checkOutput($sformatf("%s c%0d rd_addr", tag, c), 64'(bus.rd_addr), 64'(expRdAddr));
      checkOutput($sformatf("%s c%0d dog_we", tag, c),  64'(bus.dog_we),  64'(expWe));
      checkOutput($sformatf("%s c%0d done", tag, c),    64'(bus.done),    64'(expDone));
      if (expWe) begin
        checkOutput($sformatf("%s c%0d dog_addr", tag, c), 64'(bus.dog_addr), 64'(c - 3));
        checkRow($sformatf("%s c%0d din0", tag, c), bus.dog_din_0, expRow(mode, 0, c - 3));
        checkRow($sformatf("%s c%0d din1", tag, c), bus.dog_din_1, expRow(mode, 1, c - 3));
        checkRow($sformatf("%s c%0d din2", tag, c), bus.dog_din_2, expRow(mode, 2, c - 3));
        if (mode == 2)
          checkOutput($sformatf("%s c%0d tag", tag, c),
                      64'({bus.dog_din_0[DW], bus.dog_din_0[PW-1:0]}), 64'(c - 3));
      end
      if (c == ROWS + 4) begin
        checkRow({tag, " hold din0"}, bus.dog_din_0, expRow(mode, 0, ROWS - 1));
        checkRow({tag, " hold din1"}, bus.dog_din_1, expRow(mode, 1, ROWS - 1));
        checkRow({tag, " hold din2"}, bus.dog_din_2, expRow(mode, 2, ROWS - 1));
      end
      if (abortAt != 0 && c == abortAt) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkAllZero({tag, " after reset"});
        for (int j = 0; j < 8; j++) begin
          @(negedge clk);
          checkOutput($sformatf("%s post-reset %0d done", tag, j),   64'(bus.done),   64'(0));
          checkOutput($sformatf("%s post-reset %0d dog_we", tag, j), 64'(bus.dog_we), 64'(0));
          checkOutput($sformatf("%s post-reset %0d rd_en", tag, j),  64'(bus.rd_en),  64'(0));
        end
        return;
      end
      if (c < ROWS + 4) @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    curMode    = 1;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle rd_en", 64'(bus.rd_en), 64'(0));

    applyStimulus("directed", 0, 1'b0, 0);
    checkOutput("din0 px0 10->25", 64'(bus.dog_din_0[0 +: DW]),    64'(9'h00F));
    checkOutput("din2 px1 255->0", 64'(bus.dog_din_2[DW +: DW]),   64'(9'h101));
    checkOutput("din0 px5 equal",  64'(bus.dog_din_0[5*DW +: DW]), 64'(9'h000));
    @(negedge clk);

    applyStimulus("ramp", 1, 1'b0, 0);
    @(negedge clk);
    applyStimulus("repulse", 1, 1'b1, 0);
    @(negedge clk);
    applyStimulus("after-repulse", 1, 1'b0, 0);
    @(negedge clk);
    applyStimulus("reset", 1, 1'b0, 201);
    applyStimulus("post-reset", 1, 1'b0, 0);
    @(negedge clk);
    applyStimulus("tag", 2, 1'b0, 0);
    applyStimulus("b2b", 2, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
